// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared period counter, edge/centre-aligned
// counting, per-channel polarity and shadow period/duty registers applied at boundaries.
module pwm_multi #(
    parameter int NCH   = 4,
    parameter int WIDTH = 16
) (
    input  logic                 chosen_clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 pwm_en,
    input  logic                 center_mode,
    input  logic [WIDTH-1:0]     period_reg,
    input  logic [NCH*WIDTH-1:0] DC_reg,
    input  logic [NCH-1:0]       pol,
    input  logic                 load,
    output logic [WIDTH-1:0]     counter,
    output logic [NCH-1:0]       pwm,
    output logic                 period_end,
    output logic                 load_ack
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     cnt_nxt;
    logic                 boundary;
    logic                 copy_live;
    logic                 apply;

    logic [WIDTH-1:0]     per_act, per_nxt;
    logic [NCH*WIDTH-1:0] dc_act, dc_nxt;
    logic [NCH-1:0]       pol_act, pol_nxt;
    logic                 center_act, center_nxt;
    logic                 pending, pending_nxt;
    logic [NCH-1:0]       pwm_nxt;

    always_ff @(posedge chosen_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next count; counting only moves on tick edges while running.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = counter;
        boundary  = 1'b0;
        if (!pwm_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (state == IDLE) begin
            state_nxt = RUN_UP;
            cnt_nxt   = '0;
        end else if (tick) begin
            if (per_act == '0) begin
                state_nxt = RUN_UP;
                cnt_nxt   = '0;
            end else if (!center_act) begin
                state_nxt = RUN_UP;
                if (counter >= per_act - ONE) begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = counter + ONE;
                end
            end else if (state == RUN_UP) begin
                if (counter >= per_act - ONE) begin
                    state_nxt = RUN_DOWN;
                end else begin
                    cnt_nxt = counter + ONE;
                end
            end else begin
                if (counter == '0) begin
                    state_nxt = RUN_UP;
                    boundary  = 1'b1;
                end else begin
                    cnt_nxt = counter - ONE;
                end
            end
        end
    end

    // Shadow transfer and output compare, evaluated on next-state values so that
    // pwm moves on the same edge as the counter.
    always_comb begin
        copy_live   = (state == IDLE) || !pwm_en;
        apply       = !copy_live && tick && (pending || load) &&
                      (boundary || (per_act == '0));
        per_nxt     = per_act;
        dc_nxt      = dc_act;
        pol_nxt     = pol_act;
        center_nxt  = center_act;
        pending_nxt = pending | load;
        if (copy_live || apply) begin
            per_nxt     = period_reg;
            dc_nxt      = DC_reg;
            pol_nxt     = pol;
            center_nxt  = center_mode;
            pending_nxt = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            pwm_nxt[i] = pol_nxt[i] ^ (cnt_nxt < dc_nxt[i*WIDTH +: WIDTH]);
        end
        if ((state_nxt == IDLE) || (per_nxt == '0)) begin
            pwm_nxt = pol_nxt;
        end
    end

    always_ff @(posedge chosen_clk or negedge rst_n) begin
        if (!rst_n) begin
            counter    <= '0;
            pwm        <= '0;
            period_end <= 1'b0;
            load_ack   <= 1'b0;
            per_act    <= '0;
            dc_act     <= '0;
            pol_act    <= '0;
            center_act <= 1'b0;
            pending    <= 1'b0;
        end else begin
            counter    <= cnt_nxt;
            pwm        <= pwm_nxt;
            period_end <= boundary;
            load_ack   <= apply;
            per_act    <= per_nxt;
            dc_act     <= dc_nxt;
            pol_act    <= pol_nxt;
            center_act <= center_nxt;
            pending    <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed and randomized bench for pwm_multi against a period-position reference model.
module tb_pwm_multi;

    localparam int NCH   = 4;
    localparam int WIDTH = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 tick;
    logic                 pwm_en;
    logic                 center_mode;
    logic [WIDTH-1:0]     period_reg;
    logic [NCH*WIDTH-1:0] DC_reg;
    logic [NCH-1:0]       pol;
    logic                 load;
    logic [WIDTH-1:0]     counter;
    logic [NCH-1:0]       pwm;
    logic                 period_end;
    logic                 load_ack;

    pwm_multi #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .chosen_clk (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .pwm_en     (pwm_en),
        .center_mode(center_mode),
        .period_reg (period_reg),
        .DC_reg     (DC_reg),
        .pol        (pol),
        .load       (load),
        .counter    (counter),
        .pwm        (pwm),
        .period_end (period_end),
        .load_ack   (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: a running flag plus a position inside the current period
    // (0..P-1 edge-aligned, 0..2P-1 centre-aligned) and the applied settings.
    bit           m_run;
    int           m_pos;
    int           m_per;
    int           m_dc[NCH];
    logic [NCH-1:0] m_pol;
    bit           m_ctr;
    bit           m_pend;
    bit           m_pe;
    bit           m_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_per = 0; m_pol = '0; m_ctr = 0;
        m_pend = 0; m_pe = 0; m_ack = 0;
        for (int i = 0; i < NCH; i++) m_dc[i] = 0;
    endtask

    task automatic take_live();
        m_per = int'(period_reg);
        for (int i = 0; i < NCH; i++) m_dc[i] = int'(DC_reg[i*WIDTH +: WIDTH]);
        m_pol = pol;
        m_ctr = center_mode;
    endtask

    task automatic model_edge();
        m_pe  = 0;
        m_ack = 0;
        if (!m_run || !pwm_en) begin
            take_live();
            m_pend = 0;
            m_pos  = 0;
            m_run  = pwm_en;
        end else if (tick && m_per == 0) begin
            if (m_pend || load) begin
                take_live(); m_ack = 1; m_pend = 0;
            end
        end else if (tick) begin
            m_pos++;
            if (m_pos == (m_ctr ? 2 * m_per : m_per)) begin
                m_pos = 0;
                m_pe  = 1;
                if (m_pend || load) begin
                    take_live(); m_ack = 1; m_pend = 0;
                end
            end else begin
                m_pend = m_pend | load;
            end
        end else begin
            m_pend = m_pend | load;
        end
    endtask

    function automatic int exp_count();
        if (!m_run || m_per == 0) return 0;
        if (m_ctr && m_pos >= m_per) return 2 * m_per - 1 - m_pos;
        return m_pos;
    endfunction

    function automatic logic [NCH-1:0] exp_pwm();
        logic [NCH-1:0] r;
        int c;
        c = exp_count();
        for (int i = 0; i < NCH; i++)
            r[i] = m_pol[i] ^ (m_run && (m_per != 0) && (c < m_dc[i]));
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("counter", 64'(counter), 64'(exp_count()));
        chk("pwm", 64'(pwm), 64'(exp_pwm()));
        chk("period_end", 64'(period_end), 64'(m_pe));
        chk("load_ack", 64'(load_ack), 64'(m_ack));
    endtask

    task automatic set_dc(input int d0, input int d1, input int d2, input int d3);
        DC_reg[0*WIDTH +: WIDTH] = 16'(d0);
        DC_reg[1*WIDTH +: WIDTH] = 16'(d1);
        DC_reg[2*WIDTH +: WIDTH] = 16'(d2);
        DC_reg[3*WIDTH +: WIDTH] = 16'(d3);
    endtask

    int ctr_tab[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    int ch0_tab[8] = '{1, 1, 0, 0, 0, 0, 1, 1};

    initial begin
        logic [WIDTH-1:0] prev_cnt;
        logic [NCH-1:0]   prev_pwm;

        // Reset held while enabled
        rst_n = 1'b0; pwm_en = 1'b1; pol = 4'b1111; tick = 1'b1;
        center_mode = 1'b0; period_reg = '0; DC_reg = '0; load = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_counter", 64'(counter), 64'd0);
        chk("rst_pwm", 64'(pwm), 64'd0);
        chk("rst_period_end", 64'(period_end), 64'd0);
        rst_n = 1'b1; pwm_en = 1'b0;
        step();
        step();
        chk("idle_pwm_pol", 64'(pwm), 64'hF);

        // Edge-aligned 50% / 25%
        pol = '0; period_reg = 16'd4; set_dc(2, 1, 0, 0); pwm_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("edge_cnt", 64'(counter), 64'(k % 4));
            chk("edge_ch0", 64'(pwm[0]), 64'((k % 4) < 2));
            chk("edge_ch1", 64'(pwm[1]), 64'((k % 4) < 1));
            chk("edge_pe", 64'(period_end), 64'((k > 0) && (k % 4 == 0)));
        end

        // Centre-aligned
        pwm_en = 1'b0; step();
        center_mode = 1'b1; pwm_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("ctr_cnt", 64'(counter), 64'(ctr_tab[k % 8]));
            chk("ctr_ch0", 64'(pwm[0]), 64'(ch0_tab[k % 8]));
            chk("ctr_pe", 64'(period_end), 64'((k > 0) && (k % 8 == 0)));
        end

        // Saturation and inverted 0%
        pwm_en = 1'b0; step();
        center_mode = 1'b0; period_reg = 16'd3; set_dc(0, 0, 4, 0); pol = 4'b1000;
        pwm_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("sat_ch2", 64'(pwm[2]), 64'd1);
            chk("inv_ch3", 64'(pwm[3]), 64'd1);
        end

        // Shadow load mid-period
        pwm_en = 1'b0; step();
        pol = '0; period_reg = 16'd4; set_dc(1, 1, 1, 1); pwm_en = 1'b1;
        step();
        step();
        period_reg = 16'd6; set_dc(3, 3, 3, 3); load = 1'b1;
        step();
        load = 1'b0;
        chk("shadow_hold_ch0_c2", 64'(pwm[0]), 64'd0);
        step();
        chk("shadow_hold_ch0_c3", 64'(pwm[0]), 64'd0);
        chk("shadow_no_ack_yet", 64'(load_ack), 64'd0);
        step();
        chk("shadow_ack", 64'(load_ack), 64'd1);
        chk("shadow_pe", 64'(period_end), 64'd1);
        chk("shadow_new_ch0", 64'(pwm[0]), 64'd1);
        period_reg = 16'd2; set_dc(0, 0, 0, 0);
        for (int k = 1; k < 13; k++) begin
            step();
            chk("shadow_cnt", 64'(counter), 64'(k % 6));
            chk("shadow_ch0", 64'(pwm[0]), 64'((k % 6) < 3));
        end

        // Tick gating, then disable mid-period
        for (int c = 0; c < 30; c++) begin
            tick = (c % 3 == 2);
            prev_cnt = counter;
            prev_pwm = pwm;
            step();
            if (!tick) begin
                chk("gate_cnt_hold", 64'(counter), 64'(prev_cnt));
                chk("gate_pwm_hold", 64'(pwm), 64'(prev_pwm));
            end
        end
        tick = 1'b0; pol = 4'b0101; pwm_en = 1'b0;
        step();
        chk("disable_cnt", 64'(counter), 64'd0);
        chk("disable_pwm", 64'(pwm), 64'h5);

        // Randomized operation with one asynchronous reset mid-run
        pwm_en = 1'b1;
        for (int n = 0; n < 600; n++) begin
            tick        = ($urandom_range(0, 3) != 0);
            pwm_en      = ($urandom_range(0, 40) != 0);
            load        = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) center_mode = 1'($urandom_range(0, 1));
            period_reg  = 16'($urandom_range(0, 7));
            for (int i = 0; i < NCH; i++) DC_reg[i*WIDTH +: WIDTH] = 16'($urandom_range(0, 8));
            pol         = 4'($urandom_range(0, 15));
            step();
            if (n == 300) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                chk("midrst_counter", 64'(counter), 64'd0);
                chk("midrst_pwm", 64'(pwm), 64'd0);
                chk("midrst_pe", 64'(period_end), 64'd0);
                chk("midrst_ack", 64'(load_ack), 64'd0);
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
